xbar_slave_arbiter: RTL

XBAR_SLAVE_ARBITER -- requirements
Module: xbar_slave_arbiter

---
 rtl/xbar_pkg.sv | 23 ++
 rtl/xbar_rr_arb.sv | 19 +
 rtl/xbar_slave_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared widths, command encoding and arbiter state type for the slave-side crossbar arbiter.
// Imported by the arbiter, its round-robin helper and the bench.
package xbar_pkg;

  localparam int XBAR_ADDR_W = 32;
  localparam int XBAR_DATA_W = 32;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

  // Index of the set bit in a 2-bit one-hot grant (0 when bit 0 or nothing is set).
  function automatic logic onehot2_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/xbar_rr_arb.sv
// Two-way round-robin grant: purely combinational, zero latency, no backpressure of its own.
// With both requesting, the master that was not granted last wins; a lone requester always wins.
module xbar_rr_arb (
  input  logic [1:0] req_i,
  input  logic [1:0] last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_gnt_i[0] ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Arbitrates two masters onto one slave port; req->s_req 1 cycle, ack/resp pulse in a 1-cycle DONE.
// The slave stalls via s_ack/s_resp; requests arriving while a transfer is in flight are ignored.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int ADDR_W  = XBAR_ADDR_W,
  parameter int DATA_W  = XBAR_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_in,

  input  logic              m0_req,
  input  logic              m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_resp,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_resp,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              s_req,
  output logic              s_cmd,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic              s_resp,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               WD_EN    = (TIMEOUT > 0);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        last_gnt_q, last_gnt_d;
  logic [1:0]        arb_gnt;
  logic              s_req_q, s_req_d;
  logic              s_cmd_q, s_cmd_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic              rd_we;
  logic [DATA_W-1:0] rd_val;
  logic              wd_fire;
  logic              done;
  logic              is_read;

  xbar_rr_arb u_rr (
    .req_i      ({m1_req, m0_req}),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (arb_gnt)
  );

  // cnt_q counts completed wait cycles, so the TIMEOUT-th cycle is the one with cnt_q == TIMEOUT-1.
  assign wd_fire = WD_EN && (cnt_q == CNT_LAST);
  assign cnt_inc = WD_EN ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    s_req_d    = s_req_q;
    s_cmd_d    = s_cmd_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rd_we      = 1'b0;
    rd_val     = '0;

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (arb_gnt != 2'b00) begin
          gnt_d     = arb_gnt;
          s_req_d   = 1'b1;
          s_cmd_d   = onehot2_idx(arb_gnt) ? m1_cmd   : m0_cmd;
          s_addr_d  = onehot2_idx(arb_gnt) ? m1_addr  : m0_addr;
          s_wdata_d = onehot2_idx(arb_gnt) ? m1_wdata : m0_wdata;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (s_ack) begin
          s_req_d = 1'b0;
          cnt_d   = '0;
          state_d = (s_cmd_q == CMD_WRITE) ? DONE : WAIT_RESP;
        end else if (wd_fire) begin
          s_req_d = 1'b0;
          err_d   = 1'b1;
          rd_we   = (s_cmd_q == CMD_READ);
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_RESP: begin
        if (s_resp) begin
          rd_we   = 1'b1;
          rd_val  = s_rdata;
          state_d = DONE;
        end else if (wd_fire) begin
          err_d   = 1'b1;
          rd_we   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        last_gnt_d = gnt_q;
        cnt_d      = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Read data lands only in the granted master's holding register.
    if (rd_we) begin
      if (onehot2_idx(gnt_q)) rdata1_d = rd_val;
      else                    rdata0_d = rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      last_gnt_q <= 2'b10;
      s_req_q    <= 1'b0;
      s_cmd_q    <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      s_req_q    <= s_req_d;
      s_cmd_q    <= s_cmd_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign done    = (state_q == DONE);
  assign is_read = (s_cmd_q == CMD_READ);

  assign m0_ack   = done & gnt_q[0];
  assign m0_resp  = done & gnt_q[0] & is_read;
  assign m0_err   = done & gnt_q[0] & err_q;
  assign m0_rdata = rdata0_q;

  assign m1_ack   = done & gnt_q[1];
  assign m1_resp  = done & gnt_q[1] & is_read;
  assign m1_err   = done & gnt_q[1] & err_q;
  assign m1_rdata = rdata1_q;

  assign s_req   = s_req_q;
  assign s_cmd   = s_cmd_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule
